keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Drives the 4x4 matrix keypad columns and reads its rows, producing a debounced hex key code with a one-cycle valid strobe.
- It is the driving end of the fil/col keypad interface, upstream of the operand-entry FSM that consumes tecla_hex/tecla_valida in the divider top.
- Replaces the present shortcut of tying col to 0 and treating fil as the key code.

Parameters:
- SCAN_DIV, 1000, clock cycles each column stays driven (≥4).
- DEBOUNCE_CYCLES, 50000, consecutive identical samples required for press and for release (≥2).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- fil  input  4  keypad rows, active-low (pulled up; 0 = key in driven column pressed)
- col  output 4  keypad columns, active-low one-hot (one column 0, others 1)
- key_hex  output 4  code of last accepted key
- key_valid  output 1  one-cycle pulse when key_hex is updated
- key_pressed  output 1  high from acceptance until debounced release

Behaviour:
- Reset (async, rst=1), all registers cleared immediately:
  - col=4'b1110 (column index 0); key_hex=0; key_valid=0; key_pressed=0.
  - state=SCAN; column index=0; dwell and debounce counters=0; row synchronizer=4'hF.
  - Reset mid-debounce or mid-hold discards the key with no pulse.
- fil goes through a 2-flop synchronizer (fil_s); all decisions use fil_s only.
- Key map (row r, column c → hex):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E(*),0,F(#),D
- State SCAN:
  - col = ~(1<<idx). The dwell counter counts 0..SCAN_DIV-1; fil_s is sampled only at count SCAN_DIV-1, which covers settling and the synchronizer.
  - If sample==4'hF: idx←(idx+1) mod 4 (wraps 3→0), counter←0.
  - Otherwise: latch idx and the sample pattern, go to DEBOUNCE. Column is held.
- State DEBOUNCE:
  - Column held. Each cycle, compare fil_s with the latched pattern.
  - Mismatch → SCAN with idx advanced to next column, counter cleared, no pulse.
  - After DEBOUNCE_CYCLES consecutive matches: key_hex←map(lowest-index low row, latched column), key_valid=1 for exactly one cycle, key_pressed←1, go to HOLD.
- State HOLD:
  - Column held; key_pressed=1.
  - fil_s==4'hF → RELEASE, counter cleared.
  - Any change among low rows (second key, row shift) is ignored; no new pulse.
- State RELEASE:
  - Count consecutive cycles with fil_s==4'hF. Any low row → back to HOLD.
  - After DEBOUNCE_CYCLES: key_pressed←0, go to SCAN at next column, dwell counter 0.
- Multiple rows low at detection: lowest row index wins; the pattern match still uses the full 4-bit pattern.
- Multiple columns pressed: the first column scanned after the last release wins.
- key_hex holds its value between presses. key_valid never asserts in consecutive cycles.
- Minimum press-to-pulse latency: 2 (sync) + detection dwell + DEBOUNCE_CYCLES cycles. Worst case adds 3·SCAN_DIV.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8; bench models the matrix as fil[r]=0 iff key(r,c) held and col[c]==0):
- Reset: assert rst mid-scan → col=1110, key_valid=0, key_pressed=0, key_hex=0 asynchronously; after release, col walks 1110→1101→1011→0111→1110, each for 4 cycles.
- Clean press of '5' (r1,c1) for 100 cycles → exactly one key_valid pulse with key_hex=4'h5; key_pressed high until 8 cycles after release; col held at 1101 throughout.
- Bounce: press '#' (r3,c2) toggling every 3 cycles for 30 cycles, then steady → no pulse during bounce; single pulse key_hex=4'hF after the steady period.
- Release bounce: while holding 'A' (r0,c3), release with 2-cycle glitches back to pressed → key_pressed stays 1, no second pulse; clean release clears key_pressed after 8 all-high cycles.
- Two keys: hold '7' (r2,c0) and '*' (r3,c0) together → key_hex=4'h7; then press '1' while '7' is held → no pulse until '7' is released and '1' is rescanned → key_hex=4'h1.
- Reset during HOLD of '0' → key_pressed=0 immediately, no key_valid; after rst deassert with '0' still held → fresh pulse key_hex=4'h0.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanning driver for a 4x4 active-low matrix keypad.
// Walks a single low column across the matrix. When a row reads low it
// locks onto that column and debounces both the press and the release.
// The accepted key is reported as a hex code with a one-cycle strobe.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-high
//   fil[3:0]     keypad rows, active-low (pulled up)
//   col[3:0]     keypad columns, active-low one-hot
//   key_hex[3:0] code of the last accepted key (held between presses)
//   key_valid    one-cycle pulse when key_hex is updated
//   key_pressed  high from acceptance until debounced release
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fil,
  output logic [3:0] col,
  output logic [3:0] key_hex,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

  state_t           state, state_n;
  logic [1:0]       idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       pattern, pattern_n;
  logic [3:0]       hex_n;
  logic             valid_n, pressed_n;
  logic [3:0]       fil_p0, fil_p1;
  logic [3:0]       fil_s;

  // Row code and column index to the keypad legend.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Lowest-index low row; only called with at least one row low.
  function automatic logic [1:0] low_row(input logic [3:0] p);
    logic [1:0] r;
    if (!p[0])      r = 2'd0;
    else if (!p[1]) r = 2'd1;
    else if (!p[2]) r = 2'd2;
    else            r = 2'd3;
    return r;
  endfunction

  assign fil_s = fil_p1;
  assign col   = ~(4'b0001 << idx);

  // Stage p0/p1: two-flop row synchronizer, idle value is all rows high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fil_p0 <= 4'hF;
      fil_p1 <= 4'hF;
    end else begin
      fil_p0 <= fil;
      fil_p1 <= fil_p0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SCAN;
      idx         <= 2'd0;
      cnt         <= '0;
      pattern     <= 4'hF;
      key_hex     <= 4'h0;
      key_valid   <= 1'b0;
      key_pressed <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      cnt         <= cnt_n;
      pattern     <= pattern_n;
      key_hex     <= hex_n;
      key_valid   <= valid_n;
      key_pressed <= pressed_n;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt;
    pattern_n = pattern;
    hex_n     = key_hex;
    valid_n   = 1'b0;
    pressed_n = key_pressed;
    case (state)
      SCAN: begin
        // Rows are sampled only at the end of the dwell, giving the
        // column time to settle and the synchronizer time to follow.
        if (cnt == DWELL_LAST) begin
          cnt_n = '0;
          if (fil_s == 4'hF) begin
            idx_n = idx + 2'd1;
          end else begin
            pattern_n = fil_s;
            state_n   = DEBOUNCE;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      DEBOUNCE: begin
        // Full-pattern match: a second row joining or leaving restarts the scan.
        if (fil_s != pattern) begin
          state_n = SCAN;
          idx_n   = idx + 2'd1;
          cnt_n   = '0;
        end else if (cnt == DEB_LAST) begin
          hex_n     = key_code(low_row(pattern), idx);
          valid_n   = 1'b1;
          pressed_n = 1'b1;
          state_n   = HOLD;
          cnt_n     = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      HOLD: begin
        // Row changes other than a full release are ignored here.
        if (fil_s == 4'hF) begin
          state_n = RELEASE;
          cnt_n   = '0;
        end
      end
      RELEASE: begin
        if (fil_s != 4'hF) begin
          state_n = HOLD;
        end else if (cnt == DEB_LAST) begin
          pressed_n = 1'b0;
          state_n   = SCAN;
          idx_n     = idx + 2'd1;
          cnt_n     = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: state_n = SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] fil;
  logic [3:0] col;
  logic [3:0] key_hex;
  logic       key_valid;
  logic       key_pressed;

  logic [15:0] held;          // held[r*4+c] = key (r,c) physically pressed
  logic [3:0]  exp_q[$];      // expected codes, one per accepted press
  int          n_checks;
  int          n_fail;
  int          col_bad;
  logic        prev_valid;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk),
    .rst(rst),
    .fil(fil),
    .col(col),
    .key_hex(key_hex),
    .key_valid(key_valid),
    .key_pressed(key_pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive matrix: a row is pulled low when a held key joins it to a low column.
  always_comb begin
    fil = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && col[c] == 1'b0) fil[r] = 1'b0;
  end

  // Keypad legend written out from the printed key layout.
  function automatic logic [3:0] ref_code(input int r, input int c);
    if (c == 3)     return 4'(10 + r);
    else if (r < 3) return 4'(3*r + c + 1);
    else if (c == 0) return 4'hE;
    else if (c == 1) return 4'h0;
    else            return 4'hF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input int r, input int c);
    held[r*4+c] = 1'b1;
  endtask

  task automatic lift(input int r, input int c);
    held[r*4+c] = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pressed(input logic v, input int bound, input string name);
    int k;
    k = 0;
    while (key_pressed !== v && k < bound) begin
      @(negedge clk);
      k++;
    end
    check(name, key_pressed, v);
  endtask

  // Monitor: every strobe must match the oldest pending press.
  initial begin
    col_bad    = 0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (col != 4'b1110 && col != 4'b1101 && col != 4'b1011 && col != 4'b0111) col_bad++;
      if (!rst && key_valid === 1'b1) begin
        check("valid_not_back_to_back", prev_valid, 1'b0);
        check("pressed_with_valid", key_pressed, 1'b1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got key_hex %0h expected no pulse", key_hex);
        end else begin
          check("key_hex", key_hex, exp_q.pop_front());
        end
      end
      prev_valid = key_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] ecol;
    int drops, r, c;
    n_checks = 0;
    n_fail   = 0;
    held     = '0;
    rst      = 1'b1;
    cycles(3);
    check("rst_col", col, 4'b1110);
    check("rst_valid", key_valid, 1'b0);
    check("rst_pressed", key_pressed, 1'b0);
    check("rst_hex", key_hex, 4'h0);

    // Idle column walk, 4 cycles per column, wrapping 3 -> 0.
    rst = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      ecol = ~(4'b0001 << ((k / 4) % 4));
      check("col_walk", col, ecol);
      @(negedge clk);
    end
    cycles(4);
    rst = 1'b1;
    #1;
    check("async_rst_col", col, 4'b1110);
    @(negedge clk);
    rst = 1'b0;

    // Clean press of '5'.
    exp_q.push_back(ref_code(1, 1));
    press(1, 1);
    wait_pressed(1'b1, 60, "press5_accept");
    drops = 0;
    for (int k = 0; k < 60; k++) begin
      if (col != 4'b1101 || key_pressed != 1'b1) drops++;
      @(negedge clk);
    end
    check("press5_col_held", drops, 0);
    lift(1, 1);
    cycles(5);
    check("press5_release_debounce", key_pressed, 1'b1);
    wait_pressed(1'b0, 30, "press5_release");

    // Bouncing '#': no acceptance until the contact is steady.
    exp_q.push_back(ref_code(3, 2));
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) press(3, 2); else lift(3, 2);
      cycles(3);
    end
    check("bounce_no_accept", key_pressed, 1'b0);
    press(3, 2);
    wait_pressed(1'b1, 80, "bounce_accept");
    cycles(20);
    lift(3, 2);
    wait_pressed(1'b0, 40, "bounce_release");

    // 'A' with a glitchy release.
    exp_q.push_back(ref_code(0, 3));
    press(0, 3);
    wait_pressed(1'b1, 60, "a_accept");
    cycles(10);
    drops = 0;
    for (int g = 0; g < 4; g++) begin
      lift(0, 3);
      for (int k = 0; k < 3; k++) begin
        if (key_pressed != 1'b1) drops++;
        @(negedge clk);
      end
      press(0, 3);
      for (int k = 0; k < 2; k++) begin
        if (key_pressed != 1'b1) drops++;
        @(negedge clk);
      end
    end
    check("a_glitch_keeps_pressed", drops, 0);
    lift(0, 3);
    cycles(5);
    check("a_release_debounce", key_pressed, 1'b1);
    wait_pressed(1'b0, 30, "a_release");

    // Two keys in one column: lowest row wins; later keys ignored while held.
    exp_q.push_back(ref_code(2, 0));
    press(2, 0);
    press(3, 0);
    wait_pressed(1'b1, 60, "two_accept");
    cycles(10);
    press(0, 0);
    cycles(20);
    lift(2, 0);
    lift(3, 0);
    cycles(30);
    check("two_still_held", key_pressed, 1'b1);
    lift(0, 0);
    wait_pressed(1'b0, 30, "two_release");
    exp_q.push_back(ref_code(0, 0));
    press(0, 0);
    wait_pressed(1'b1, 60, "one_accept");
    cycles(8);
    lift(0, 0);
    wait_pressed(1'b0, 30, "one_release");

    // Reset while idle clears the held code.
    cycles(3);
    rst = 1'b1;
    #1;
    check("rst_idle_hex", key_hex, 4'h0);
    check("rst_idle_col", col, 4'b1110);
    @(negedge clk);
    rst = 1'b0;

    // Reset during HOLD of '0', then a fresh acceptance.
    exp_q.push_back(ref_code(3, 1));
    press(3, 1);
    wait_pressed(1'b1, 60, "zero_accept");
    cycles(5);
    rst = 1'b1;
    #1;
    check("rst_hold_pressed", key_pressed, 1'b0);
    check("rst_hold_valid", key_valid, 1'b0);
    cycles(3);
    rst = 1'b0;
    exp_q.push_back(ref_code(3, 1));
    wait_pressed(1'b1, 60, "zero_reaccept");
    cycles(5);
    lift(3, 1);
    wait_pressed(1'b0, 30, "zero_release");

    // Randomized single-key presses.
    for (int n = 0; n < 16; n++) begin
      r = int'($urandom_range(3, 0));
      c = int'($urandom_range(3, 0));
      exp_q.push_back(ref_code(r, c));
      press(r, c);
      wait_pressed(1'b1, 60, "rand_accept");
      cycles(int'($urandom_range(20, 0)));
      lift(r, c);
      wait_pressed(1'b0, 30, "rand_release");
      cycles(int'($urandom_range(10, 0)));
    end

    cycles(20);
    check("all_presses_strobed", exp_q.size(), 0);
    check("col_one_hot_low", col_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
